hmac_msg_packer: RTL and testbench
==================================

# hmac_msg_packer

Input stage of the HMAC-Ascon datapath: accepts a message as a byte stream over a valid/ready handshake and packs it into 64-bit Ascon rate blocks with Ascon padding. Blocks are presented to the HMAC state machine (its message-save step) over a second valid/ready handshake. The block also keeps a byte count of the current message. One message is in flight at a time, and every message is at least 1 byte long.

## Interface
- LEN_W, 16: width of the message byte counter.
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a byte is offered on in_data.
- in_data  in  8  message byte.
- in_last  in  1  qualifies in_valid: this is the final byte of the message.
- in_ready  out  1  the packer can accept a byte this cycle.
- blk_valid  out  1  blk_data/blk_last hold a valid block.
- blk_data  out  64  packed rate block; the first byte sits in [63:56].
- blk_last  out  1  this block is the final, padded block of the message.
- blk_ready  in  1  the consumer takes the block this cycle.
- msg_len  out  LEN_W  count of bytes accepted for the current or most recent message.
- msg_done  out  1  one-cycle pulse on the handshake of the final block.

## Operation
- **States:**
  - FILL: in_ready=1, blk_valid=0.
  - EMIT: blk_valid=1, holds a data block.
  - EMIT_PAD: blk_valid=1, holds the padding-only block.
- **FILL, byte acceptance:**
  - A byte is accepted when in_valid & in_ready.
  - Byte k of the block (k=0..7) is written to bits [63-8k:56-8k].
  - The byte index increments after each accepted byte.
- **FILL, non-last byte at index 7:** the full block is registered with blk_last=0, the index wraps to 0, and the state goes to EMIT.
- **FILL, last byte at index k<7:**
  - Byte k+1 is set to 0x80 and all later bytes to 0x00.
  - blk_last=1, the index resets to 0, and the state goes to EMIT.
- **FILL, last byte at index 7:**
  - The full block is emitted with blk_last=0 and a pad_pending flag is set.
  - The state goes to EMIT.
- **EMIT, on blk_ready:**
  - If pad_pending: blk_data=0x8000_0000_0000_0000, blk_last=1, pad_pending cleared, state goes to EMIT_PAD.
  - Otherwise: state goes to FILL.
- **EMIT_PAD, on blk_ready:** state goes to FILL.
- **msg_done:** pulses high in the cycle of the blk_ready handshake for any block with blk_last=1.
- **msg_len:**
  - Increments by 1 on every accepted byte.
  - Saturates at 2^LEN_W-1.
  - Holds its final value after msg_done.
  - The first byte accepted after msg_done loads the counter with 1.
- **Unused bits of a partially built block:** bytes not yet written in the staging register are 0x00. The register is cleared after each block handshake.

## Timing
- **Reset values:**
  - State FILL, index 0, pad_pending 0.
  - blk_valid=0, blk_data=0, blk_last=0, msg_done=0, msg_len=0.
  - in_ready=1, since it is decoded from the state.
- **Latency:** blk_valid rises in the cycle after the byte that completes or terminates a block is accepted.
- **in_ready:** low in EMIT and EMIT_PAD.
- **Throughput:** with blk_ready held high, a full block takes 8 accept cycles plus 1 emit cycle.
- **Output hold:** while blk_valid=1 and blk_ready=0, blk_data and blk_last are held stable.
- **Inputs outside FILL:** in_valid and in_last are ignored when in_ready=0.
- **blk_valid after reset:** never deasserts without a handshake.
- **Reset mid-operation:** any partial block, pad_pending flag, and pending block are discarded, and all outputs return to their reset values immediately (asynchronous reset).
- **in_last outside FILL:** has no effect unless accepted in FILL.

## Test plan
- **Short message:** bytes 61,62,63 with in_last on 63, blk_ready=1.
  - Expect one block 0x6162_6380_0000_0000, blk_last=1.
  - msg_done pulses once; msg_len=3.
- **Exact 8-byte message:** bytes 00..07, last on 07.
  - Expect block 0x0001_0203_0405_0607 with blk_last=0.
  - Then block 0x8000_0000_0000_0000 with blk_last=1.
  - msg_len=8; in_ready stays low across both blocks.
- **10-byte message:** bytes 00..09.
  - Expect block 0x0001_0203_0405_0607 with blk_last=0.
  - Then block 0x0809_8000_0000_0000 with blk_last=1; msg_len=10.
- **Backpressure:** hold blk_ready=0 for 5 cycles after blk_valid rises.
  - blk_data and blk_last stay unchanged and in_ready=0 throughout.
  - The block is consumed exactly once when blk_ready=1.
- **Reset mid-message:** accept bytes 11,22,33, pulse rst_n low, then send byte 64 with last.
  - Expect block 0x6480_0000_0000_0000; msg_len=1.
  - No trace of the earlier bytes.
- **Counter saturation:** LEN_W=4, send a 20-byte message, then a 2-byte message.
  - msg_len ends at 15 after the first message.
  - msg_len reads 1 after the first byte of the second message and 2 at its msg_done.

Source files
------------

// File: rtl/hmac_msg_packer.sv
// Byte-stream to 64-bit Ascon rate-block packer with Ascon padding for the HMAC-Ascon datapath.
// Also tracks a saturating byte count of the current message.
module hmac_msg_packer #(
   parameter int unsigned LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             blk_valid,
   output logic [63:0]      blk_data,
   output logic             blk_last,
   input  logic             blk_ready,
   output logic [LEN_W-1:0] msg_len,
   output logic             msg_done
);

   typedef enum logic [1:0] {FILL, EMIT, EMIT_PAD} state_e;

   state_e             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic               pad_pending_q, pad_pending_d;
   logic [63:0]        stage_q, stage_d;
   logic [63:0]        blk_data_q, blk_data_d;
   logic               blk_last_q, blk_last_d;
   logic [LEN_W-1:0]   msg_len_q, msg_len_d;
   logic               new_msg_q, new_msg_d;
   logic [63:0]        assembled;
   logic               accept;
   logic               handshake;

   assign in_ready  = (state_q == FILL);
   assign blk_valid = (state_q != FILL);
   assign blk_data  = blk_data_q;
   assign blk_last  = blk_last_q;
   assign msg_len   = msg_len_q;
   assign accept    = in_valid & in_ready;
   assign handshake = blk_valid & blk_ready;
   assign msg_done  = handshake & blk_last_q;

   // Staging register with the incoming byte merged in; a last byte below index 7 also gets the 0x80 pad.
   always_comb begin
      assembled = stage_q;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i == {29'd0, idx_q}) begin
            assembled[63-8*i -: 8] = in_data;
         end else if (in_last && (i == {29'd0, idx_q} + 32'd1)) begin
            assembled[63-8*i -: 8] = 8'h80;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      pad_pending_d = pad_pending_q;
      stage_d       = stage_q;
      blk_data_d    = blk_data_q;
      blk_last_d    = blk_last_q;
      msg_len_d     = msg_len_q;
      new_msg_d     = new_msg_q;

      if (accept) begin
         new_msg_d = 1'b0;
         if (new_msg_q) begin
            msg_len_d = {{(LEN_W-1){1'b0}}, 1'b1};
         end else if (msg_len_q != '1) begin
            msg_len_d = msg_len_q + {{(LEN_W-1){1'b0}}, 1'b1};
         end
      end

      case (state_q)
         FILL: begin
            if (accept) begin
               if (in_last || (idx_q == 3'd7)) begin
                  blk_data_d    = assembled;
                  blk_last_d    = in_last && (idx_q != 3'd7);
                  pad_pending_d = in_last && (idx_q == 3'd7);
                  stage_d       = '0;
                  idx_d         = '0;
                  state_d       = EMIT;
               end else begin
                  stage_d = assembled;
                  idx_d   = idx_q + 3'd1;
               end
            end
         end
         EMIT: begin
            if (blk_ready) begin
               if (pad_pending_q) begin
                  blk_data_d    = 64'h8000_0000_0000_0000;
                  blk_last_d    = 1'b1;
                  pad_pending_d = 1'b0;
                  state_d       = EMIT_PAD;
               end else begin
                  blk_data_d = '0;
                  blk_last_d = 1'b0;
                  state_d    = FILL;
               end
            end
         end
         EMIT_PAD: begin
            if (blk_ready) begin
               blk_data_d = '0;
               blk_last_d = 1'b0;
               state_d    = FILL;
            end
         end
         default: state_d = FILL;
      endcase

      if (msg_done) begin
         new_msg_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FILL;
         idx_q         <= '0;
         pad_pending_q <= 1'b0;
         stage_q       <= '0;
         blk_data_q    <= '0;
         blk_last_q    <= 1'b0;
         msg_len_q     <= '0;
         new_msg_q     <= 1'b1;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         pad_pending_q <= pad_pending_d;
         stage_q       <= stage_d;
         blk_data_q    <= blk_data_d;
         blk_last_q    <= blk_last_d;
         msg_len_q     <= msg_len_d;
         new_msg_q     <= new_msg_d;
      end
   end

endmodule

// File: tb/tb_hmac_msg_packer.sv
// Bench for hmac_msg_packer: directed vector table, mid-message reset, and random messages
// scored against a padding/blocking reference model; a LEN_W=4 copy shares the stimulus.
module tb_hmac_msg_packer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        blk_ready;

   logic        in_ready,  in_ready4;
   logic        blk_valid, blk_valid4;
   logic [63:0] blk_data,  blk_data4;
   logic        blk_last,  blk_last4;
   logic [15:0] msg_len;
   logic [3:0]  msg_len4;
   logic        msg_done,  msg_done4;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [7:0]  msg_q[$];
   logic [64:0] exp_q[$];

   typedef struct {
      int unsigned n;
      logic [7:0]  first;
      int unsigned mode;
      logic        pre_reset;
      int unsigned nblk;
      logic [63:0] d0;
      logic        l0;
      logic [63:0] d1;
   } vec_t;

   vec_t vecs[6];

   hmac_msg_packer #(.LEN_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready), .blk_valid(blk_valid), .blk_data(blk_data), .blk_last(blk_last),
      .blk_ready(blk_ready), .msg_len(msg_len), .msg_done(msg_done)
   );

   hmac_msg_packer #(.LEN_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready4), .blk_valid(blk_valid4), .blk_data(blk_data4), .blk_last(blk_last4),
      .blk_ready(blk_ready), .msg_len(msg_len4), .msg_done(msg_done4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [63:0] satlen(input int unsigned n, input int unsigned w);
      longint unsigned m;
      m = (64'd1 << w) - 64'd1;
      return (longint'(n) > m) ? m : 64'(n);
   endfunction

   // Reference: append 0x80, zero-fill to a multiple of 8 bytes, cut into big-endian words.
   task automatic build_expected();
      logic [7:0]  p[$];
      logic [63:0] w;
      p = msg_q;
      p.push_back(8'h80);
      while (p.size() % 8 != 0) p.push_back(8'h00);
      exp_q.delete();
      for (int i = 0; i < p.size(); i += 8) begin
         w = '0;
         for (int j = 0; j < 8; j++) w = {w[55:0], p[i+j]};
         exp_q.push_back({(i + 8 == p.size()), w});
      end
   endtask

   // mode 0: always valid/ready; 1: random gaps; 2: ready held low 5 cycles per block
   task automatic run_msg(input int unsigned mode);
      int unsigned bi = 0, cyc = 0, stall = 0, nmsg;
      logic        hold_v = 1'b0, hold_l = 1'b0, just_acc = 1'b0, exp_done;
      logic [63:0] hold_d = '0;
      logic [64:0] e;
      nmsg = msg_q.size();
      while ((bi < nmsg || exp_q.size() != 0) && cyc < 400) begin
         @(negedge clk);
         in_valid = (bi < nmsg) && (mode != 1 || $urandom_range(0, 3) != 0);
         in_data  = (bi < nmsg) ? msg_q[bi] : 8'h00;
         in_last  = in_valid && (bi + 1 == nmsg);
         if (mode == 0) blk_ready = 1'b1;
         else if (mode == 1) blk_ready = 1'($urandom_range(0, 1));
         else if (blk_valid && stall < 5) begin blk_ready = 1'b0; stall++; end
         else blk_ready = 1'b1;
         #1;
         if (hold_v) begin
            chk("hold_valid", blk_valid, 1);
            chk("hold_data", blk_data, hold_d);
            chk("hold_last", blk_last, hold_l);
         end
         if (blk_valid) chk("in_ready_low", in_ready, 0);
         if (just_acc) begin
            chk("msg_len", msg_len, satlen(bi, 16));
            chk("msg_len4", msg_len4, satlen(bi, 4));
         end
         just_acc = 1'b0;
         exp_done = 1'b0;
         if (blk_valid && blk_ready) begin
            stall = 0;
            chk("block_outstanding", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("blk_data", blk_data, e[63:0]);
               chk("blk_last", blk_last, e[64]);
               chk("blk_data4", blk_data4, e[63:0]);
               chk("blk_last4", blk_last4, e[64]);
               exp_done = e[64];
               if (e[64]) begin
                  chk("msg_len_done", msg_len, satlen(nmsg, 16));
                  chk("msg_len4_done", msg_len4, satlen(nmsg, 4));
               end
            end
         end
         chk("msg_done", msg_done, exp_done);
         chk("msg_done4", msg_done4, exp_done);
         if (in_valid && in_ready) begin bi++; just_acc = 1'b1; end
         hold_v = blk_valid && !blk_ready;
         hold_d = blk_data;
         hold_l = blk_last;
         cyc++;
      end
      if (bi < nmsg || exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL timeout: sent %0d of %0d bytes, %0d blocks outstanding", bi, nmsg, exp_q.size());
         exp_q.delete();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic mid_reset();
      logic [7:0] b[3];
      b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = b[i]; in_last = 1'b0; blk_ready = 1'b1;
         #1 chk("pre_rst_ready", in_ready, 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("pre_rst_len", msg_len, 3);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_blk_valid", blk_valid, 0);
      chk("rst_blk_data", blk_data, 0);
      chk("rst_msg_len", msg_len, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; blk_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_blk_valid", blk_valid, 0);
      chk("reset_blk_data", blk_data, 0);
      chk("reset_blk_last", blk_last, 0);
      chk("reset_msg_done", msg_done, 0);
      chk("reset_msg_len", msg_len, 0);
      chk("reset_in_ready", in_ready, 1);
      rst_n = 1'b1;

      vecs[0] = '{3,  8'h61, 0, 1'b0, 1, 64'h6162_6380_0000_0000, 1'b1, 64'h0};
      vecs[1] = '{8,  8'h00, 0, 1'b0, 2, 64'h0001_0203_0405_0607, 1'b0, 64'h8000_0000_0000_0000};
      vecs[2] = '{10, 8'h00, 0, 1'b0, 2, 64'h0001_0203_0405_0607, 1'b0, 64'h0809_8000_0000_0000};
      vecs[3] = '{5,  8'hA0, 2, 1'b0, 1, 64'hA0A1_A2A3_A480_0000, 1'b1, 64'h0};
      vecs[4] = '{8,  8'hF0, 2, 1'b0, 2, 64'hF0F1_F2F3_F4F5_F6F7, 1'b0, 64'h8000_0000_0000_0000};
      vecs[5] = '{1,  8'h64, 0, 1'b1, 1, 64'h6480_0000_0000_0000, 1'b1, 64'h0};

      foreach (vecs[k]) begin
         if (vecs[k].pre_reset) mid_reset();
         msg_q.delete();
         for (int unsigned i = 0; i < vecs[k].n; i++) msg_q.push_back(8'(vecs[k].first + i));
         exp_q.delete();
         exp_q.push_back({vecs[k].l0, vecs[k].d0});
         if (vecs[k].nblk == 2) exp_q.push_back({1'b1, vecs[k].d1});
         run_msg(vecs[k].mode);
      end

      // 20 bytes saturate the LEN_W=4 counter at 15; the 2-byte follow-up restarts it at 1.
      msg_q.delete();
      for (int i = 0; i < 20; i++) msg_q.push_back(8'($urandom));
      build_expected();
      run_msg(1);
      msg_q.delete();
      for (int i = 0; i < 2; i++) msg_q.push_back(8'($urandom));
      build_expected();
      run_msg(1);

      for (int m = 0; m < 25; m++) begin
         msg_q.delete();
         for (int unsigned i = 0; i < $urandom_range(1, 20); i++) msg_q.push_back(8'($urandom));
         build_expected();
         run_msg($urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
